// File: rtl/road_frame_renderer.sv
// Scrolling road frame generator: on each scroll step it advances a vertical offset
// and streams one full frame of pixels (x, y, colour, plot) to vga_adapter, one per clock.
module road_frame_renderer #(
  parameter int XSCREEN    = 160,
  parameter int YSCREEN    = 120,
  parameter int ROAD_LEFT  = 40,
  parameter int ROAD_RIGHT = 119,
  parameter int CENTER_X   = 79,
  parameter int DASH_LEN   = 8,
  parameter int STEP       = 1,
  parameter int INIT_DRAW  = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic [6:0] scroll_offset,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] x_n;
  logic [6:0] y_n;
  logic [2:0] colour_n;
  logic       plot_n, busy_n, frame_done_n;
  logic [6:0] offset_n, offset_stepped;
  logic [7:0] offset_sum;
  logic       pending, pending_n;
  logic       init_req, init_req_n;
  logic       overrun_n;

  // Road row ay is the screen row shifted back by the offset, so dashes move down.
  function automatic logic [2:0] pixel_colour(input logic [7:0] px, input logic [6:0] py,
                                              input logic [6:0] off);
    logic [7:0] ay;
    ay = {1'b0, py} + 8'(YSCREEN) - {1'b0, off};
    if (ay >= 8'(YSCREEN)) ay = ay - 8'(YSCREEN);
    if (px < 8'(ROAD_LEFT) || px > 8'(ROAD_RIGHT))
      return 3'b010;
    else if (px == 8'(ROAD_LEFT) || px == 8'(ROAD_RIGHT))
      return 3'b111;
    else if ((px == 8'(CENTER_X) || px == 8'(CENTER_X + 1)) &&
             ((ay % 8'(2 * DASH_LEN)) < 8'(DASH_LEN)))
      return 3'b110;
    else
      return 3'b000;
  endfunction

  assign offset_sum     = {1'b0, scroll_offset} + 8'(STEP);
  assign offset_stepped = (offset_sum >= 8'(YSCREEN)) ? 7'(offset_sum - 8'(YSCREEN))
                                                      : offset_sum[6:0];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n      = state;
    x_n          = x;
    y_n          = y;
    colour_n     = colour;
    plot_n       = 1'b0;
    frame_done_n = 1'b0;
    offset_n     = scroll_offset;
    pending_n    = pending;
    init_req_n   = init_req;
    overrun_n    = overrun;

    case (state)
      IDLE: begin
        if (step || pending || init_req) begin
          if (step || pending) offset_n = offset_stepped;
          // Only one step is consumed per start; a coincident second one is lost.
          if (step && pending) overrun_n = 1'b1;
          pending_n  = 1'b0;
          init_req_n = 1'b0;
          x_n        = '0;
          y_n        = '0;
          colour_n   = pixel_colour(8'd0, 7'd0, offset_n);
          plot_n     = 1'b1;
          state_n    = DRAW;
        end
      end
      DRAW: begin
        if (x == 8'(XSCREEN - 1) && y == 7'(YSCREEN - 1)) begin
          frame_done_n = 1'b1;
          state_n      = DONE;
        end else begin
          if (x == 8'(XSCREEN - 1)) begin
            x_n = '0;
            y_n = y + 7'd1;
          end else begin
            x_n = x + 8'd1;
          end
          colour_n = pixel_colour(x_n, y_n, scroll_offset);
          plot_n   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state != IDLE && step) begin
      if (!pending) pending_n = 1'b1;
      else          overrun_n = 1'b1;
    end
  end

  // plot and busy both mean "a pixel is on the bus this cycle".
  assign busy_n = plot_n;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      scroll_offset <= '0;
      pending       <= 1'b0;
      init_req      <= (INIT_DRAW != 0);
      overrun       <= 1'b0;
    end else begin
      state         <= state_n;
      x             <= x_n;
      y             <= y_n;
      colour        <= colour_n;
      plot          <= plot_n;
      busy          <= busy_n;
      frame_done    <= frame_done_n;
      scroll_offset <= offset_n;
      pending       <= pending_n;
      init_req      <= init_req_n;
      overrun       <= overrun_n;
    end
  end

endmodule

// File: tb/tb_road_frame_renderer.sv
// Directed bench for road_frame_renderer: full-size frames plus a tiny-geometry
// instance used to exercise offset wrap within a short run.
module tb_road_frame_renderer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       step = 1'b0;
  logic       step2 = 1'b0;
  logic [7:0] x, x2;
  logic [6:0] y, y2;
  logic [2:0] colour, colour2;
  logic       plot, plot2, busy, busy2, frame_done, frame_done2, overrun, overrun2;
  logic [6:0] scroll_offset, scroll_offset2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] frame_col [0:19199];
  int   cap_plots, cap_order_err, cap_off;
  logic cap_done, cap_timeout;

  always #10 CLOCK_50 = ~CLOCK_50;

  road_frame_renderer dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .step(step),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
    .frame_done(frame_done), .scroll_offset(scroll_offset), .overrun(overrun)
  );

  road_frame_renderer #(.XSCREEN(8), .YSCREEN(4), .INIT_DRAW(0)) dut_small (
    .CLOCK_50(CLOCK_50), .reset(reset), .step(step2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2),
    .frame_done(frame_done2), .scroll_offset(scroll_offset2), .overrun(overrun2)
  );

  function automatic logic [2:0] exp_colour(input int px, input int py, input int off);
    int ay;
    ay = (py - off + 120) % 120;
    if (px < 40 || px > 119)                   return 3'b010;
    if (px == 40 || px == 119)                 return 3'b111;
    if ((px == 79 || px == 80) && (ay % 16) < 8) return 3'b110;
    return 3'b000;
  endfunction

  function automatic int model_errors(input int off);
    int errs = 0;
    for (int i = 0; i < 19200; i++)
      if (frame_col[i] !== exp_colour(i % 160, i / 160, off)) errs++;
    return errs;
  endfunction

  task automatic pulse_step();
    step = 1'b1;
    @(negedge CLOCK_50);
    step = 1'b0;
  endtask

  // Records one frame of the main DUT; ordering/busy/offset slips are tallied.
  task automatic capture_frame();
    int w = 0;
    cap_plots = 0; cap_order_err = 0; cap_done = 1'b0; cap_timeout = 1'b0; cap_off = -1;
    while (plot !== 1'b1 && w < 64) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (plot !== 1'b1) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_off = int'(scroll_offset);
    while (plot === 1'b1 && cap_plots < 19300) begin
      if (x !== 8'(cap_plots % 160) || y !== 7'(cap_plots / 160) || busy !== 1'b1 ||
          frame_done !== 1'b0 || int'(scroll_offset) != cap_off)
        cap_order_err++;
      else if (cap_plots < 19200)
        frame_col[cap_plots] = colour;
      cap_plots++;
      @(negedge CLOCK_50);
    end
    cap_done = frame_done;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLOCK_50);
    n_checks++;
    if ({x, y, colour, plot, busy, frame_done, scroll_offset, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d col=%b plot=%b busy=%b done=%b off=%0d ovr=%b, want all 0",
               x, y, colour, plot, busy, frame_done, scroll_offset, overrun);
    end
    n_checks++;
    if (plot2 !== 1'b0 || scroll_offset2 !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_small: got plot=%b off=%0d, want 0 0", plot2, scroll_offset2);
    end
  endtask

  task automatic test_init_frame();
    int px [9] = '{0, 40, 79, 79, 100, 119, 80, 39, 120};
    int py [9] = '{0, 0, 0, 8, 5, 0, 0, 0, 0};
    logic [2:0] pc [9] = '{3'b010, 3'b111, 3'b110, 3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b010};
    int idle_bad = 0;
    reset = 1'b0;
    capture_frame();
    n_checks++;
    if (cap_timeout || cap_plots != 19200) begin
      n_fail++;
      $display("FAIL init_plots: got %0d (timeout=%b), want 19200", cap_plots, cap_timeout);
    end
    n_checks++;
    if (cap_order_err != 0) begin
      n_fail++;
      $display("FAIL init_order: got %0d ordering/busy errors, want 0", cap_order_err);
    end
    n_checks++;
    if (cap_off != 0) begin
      n_fail++;
      $display("FAIL init_offset: got %0d, want 0", cap_off);
    end
    n_checks++;
    if (cap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL init_frame_done: got %b, want 1", cap_done);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (frame_col[py[i] * 160 + px[i]] !== pc[i]) begin
        n_fail++;
        $display("FAIL init_pixel(%0d,%0d): got %b, want %b", px[i], py[i],
                 frame_col[py[i] * 160 + px[i]], pc[i]);
      end
    end
    n_checks++;
    if (model_errors(0) != 0) begin
      n_fail++;
      $display("FAIL init_model: got %0d colour errors, want 0", model_errors(0));
    end
    repeat (6) begin
      @(negedge CLOCK_50);
      if (plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) idle_bad++;
    end
    n_checks++;
    if (idle_bad != 0) begin
      n_fail++;
      $display("FAIL init_idle: got %0d active idle cycles, want 0", idle_bad);
    end
  endtask

  task automatic test_step_overrun();
    int px [3] = '{79, 79, 79};
    int py [3] = '{0, 8, 9};
    logic [2:0] pc [3] = '{3'b110, 3'b110, 3'b000};
    int extra = 0;
    pulse_step();
    fork
      capture_frame();
      begin
        repeat (100) @(negedge CLOCK_50);
        pulse_step();
        repeat (100) @(negedge CLOCK_50);
        pulse_step();
      end
    join
    n_checks++;
    if (cap_off != 1 || cap_plots != 19200 || cap_order_err != 0 || cap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL step_frame: got off=%0d plots=%0d err=%0d done=%b, want 1 19200 0 1",
               cap_off, cap_plots, cap_order_err, cap_done);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (frame_col[py[i] * 160 + px[i]] !== pc[i]) begin
        n_fail++;
        $display("FAIL step_pixel(%0d,%0d): got %b, want %b", px[i], py[i],
                 frame_col[py[i] * 160 + px[i]], pc[i]);
      end
    end
    n_checks++;
    if (model_errors(1) != 0) begin
      n_fail++;
      $display("FAIL step_model: got %0d colour errors, want 0", model_errors(1));
    end
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b, want 1", overrun);
    end
    capture_frame();
    n_checks++;
    if (cap_off != 2 || cap_plots != 19200 || cap_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_frame: got off=%0d plots=%0d done=%b, want 2 19200 1",
               cap_off, cap_plots, cap_done);
    end
    repeat (40) begin
      @(negedge CLOCK_50);
      if (plot !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL no_third_frame: got %0d extra plots, overrun=%b, want 0 1", extra, overrun);
    end
  endtask

  task automatic test_wrap();
    int exp_off [5] = '{1, 2, 3, 0, 1};
    int max_off = 0;
    for (int k = 0; k < 5; k++) begin
      int plots = 0;
      int w = 0;
      logic seen_done = 1'b0;
      step2 = 1'b1;
      @(negedge CLOCK_50);
      step2 = 1'b0;
      if (k == 0) begin
        n_checks++;
        if (plot2 !== 1'b1 || busy2 !== 1'b1 || x2 !== 8'd0 || y2 !== 7'd0 || colour2 !== 3'b010) begin
          n_fail++;
          $display("FAIL small_first_pixel: got plot=%b busy=%b x=%0d y=%0d col=%b, want 1 1 0 0 010",
                   plot2, busy2, x2, y2, colour2);
        end
      end
      while (!seen_done && w < 100) begin
        if (plot2 === 1'b1) plots++;
        if (frame_done2 === 1'b1) seen_done = 1'b1;
        if (int'(scroll_offset2) > max_off) max_off = int'(scroll_offset2);
        if (!seen_done) @(negedge CLOCK_50);
        w++;
      end
      n_checks++;
      if (!seen_done || plots != 32 || int'(scroll_offset2) != exp_off[k]) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got off=%0d plots=%0d done=%b, want %0d 32 1",
                 k, scroll_offset2, plots, seen_done, exp_off[k]);
      end
      @(negedge CLOCK_50);
    end
    n_checks++;
    if (max_off > 3 || overrun2 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_range: got max_off=%0d overrun=%b, want <=3 0", max_off, overrun2);
    end
  endtask

  task automatic test_reset_midframe();
    int w = 0;
    int done_seen = 0;
    pulse_step();
    while (!(plot === 1'b1 && x === 8'd50 && y === 7'd60) && w < 20000) begin
      @(negedge CLOCK_50);
      w++;
    end
    n_checks++;
    if (!(plot === 1'b1 && x === 8'd50 && y === 7'd60)) begin
      n_fail++;
      $display("FAIL midframe_reach: got x=%0d y=%0d plot=%b, want 50 60 1", x, y, plot);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({plot, busy, x, y, colour, scroll_offset, overrun} !== '0) begin
      n_fail++;
      $display("FAIL midframe_abort: got plot=%b x=%0d y=%0d col=%b off=%0d ovr=%b, want all 0",
               plot, x, y, colour, scroll_offset, overrun);
    end
    repeat (3) begin
      @(negedge CLOCK_50);
      if (frame_done !== 1'b0 || plot !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL midframe_no_done: got %0d active cycles in reset, want 0", done_seen);
    end
    reset = 1'b0;
    @(negedge CLOCK_50);
    n_checks++;
    if (plot !== 1'b1 || x !== 8'd0 || y !== 7'd0 || scroll_offset !== 7'd0 || colour !== 3'b010) begin
      n_fail++;
      $display("FAIL midframe_restart: got plot=%b x=%0d y=%0d off=%0d col=%b, want 1 0 0 0 010",
               plot, x, y, scroll_offset, colour);
    end
  endtask

  initial begin
    test_reset();
    test_init_frame();
    test_step_overrun();
    test_wrap();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/road_frame_renderer.md
Name: road_frame_renderer

Overview:
- Pixel-stream generator feeding the vga_adapter x/y/colour/plot inputs, one pixel per clock.
- On each scroll step it advances a vertical scroll offset and redraws the full 160x120 road frame: grass, road surface, edge lines, and a dashed centre line.
- Dash phase tracks the offset, so the road appears to move down the screen.
- Sits between the speed-tick generator (upstream) and vga_adapter (downstream).

Parameters:
XSCREEN, 160, pixel columns; x range 0..XSCREEN-1.
YSCREEN, 120, pixel rows; y range 0..YSCREEN-1.
ROAD_LEFT, 40, first road column; also the left edge-line column.
ROAD_RIGHT, 119, last road column; also the right edge-line column.
CENTER_X, 79, centre line occupies columns CENTER_X and CENTER_X+1.
DASH_LEN, 8, dash length and gap length in rows; the dash period is 2*DASH_LEN.
STEP, 1, rows the offset advances per accepted step; legal range 1..YSCREEN-1.
INIT_DRAW, 1, when 1, one frame at offset 0 is drawn automatically after reset release.

Ports:
CLOCK_50  input  1  system clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-high reset.
step  input  1  single-cycle scroll request, from the speed-tick OR.
x  output  8  pixel column to vga_adapter.
y  output  7  pixel row to vga_adapter.
colour  output  3  RGB, 1 bit per channel.
plot  output  1  write strobe; x, y and colour are valid whenever plot=1.
busy  output  1  high while in DRAW.
frame_done  output  1  one-cycle pulse after the last pixel of a frame.
scroll_offset  output  7  current offset, 0..YSCREEN-1.
overrun  output  1  sticky flag; set when a step is dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; x=0, y=0, colour=0, plot=0, frame_done=0, scroll_offset=0, pending=0, overrun=0.
  - init_req=INIT_DRAW.
- All outputs are registered.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - If step, pending or init_req is set, start a frame.
  - On a start from step or pending, update the offset: scroll_offset <= scroll_offset+STEP, minus YSCREEN if the sum is >= YSCREEN. Compute the sum on 8 bits so it cannot overflow.
  - On a start from init_req only, the offset is unchanged.
  - Clear init_req and pending on start. Set x=0, y=0 and go to DRAW.
  - plot=0 while in IDLE.
- DRAW:
  - plot=1 every cycle; each cycle presents one pixel (x,y) with its colour.
  - After each pixel, x increments. At x=XSCREEN-1, x wraps to 0 and y increments.
  - After pixel (XSCREEN-1, YSCREEN-1), go to DONE.
  - A frame is exactly XSCREEN*YSCREEN = 19200 plot cycles. The first plot occurs the cycle after the start decision.
- DONE:
  - One cycle with plot=0 and frame_done=1, then return to IDLE.
- Colour function for pixel (x,y), using the offset latched at frame start:
  - ay = (y + YSCREEN - scroll_offset) mod YSCREEN; compute on 8 bits with a single conditional subtract.
  - x < ROAD_LEFT or x > ROAD_RIGHT: green, 3'b010.
  - x == ROAD_LEFT or x == ROAD_RIGHT: white, 3'b111.
  - x == CENTER_X or CENTER_X+1, and (ay mod 2*DASH_LEN) < DASH_LEN: yellow, 3'b110.
  - Any other road pixel: black, 3'b000.
  - Colour is registered together with x and y (same cycle as plot).
- Step while busy (DRAW or DONE):
  - If pending=0, set pending=1.
  - If pending=1, the step is dropped and overrun is set. overrun stays set until reset.
  - A step arriving in the same IDLE cycle as a pending-driven start is also dropped and sets overrun. At most one step is consumed per start.
- scroll_offset changes only at a start decision; it is stable for the whole frame.
- Reset during DRAW aborts the frame immediately (plot drops asynchronously); no frame_done is issued.

Test Plan:
- Reset release with INIT_DRAW=1, no step → frame of 19200 plot cycles, offset 0; pixel (0,0)=3'b010, (40,0)=3'b111, (79,0)=3'b110, (79,8)=3'b000, (100,5)=3'b000; frame_done one cycle after (159,119); then idle with plot=0.
- Single step in IDLE, offset 0 → scroll_offset=1 at start; pixel (79,0) gives ay=119, 119 mod 16=7 <8 → 3'b110; pixel (79,8) gives ay=7 → 3'b110; pixel (79,9) gives ay=8 → 3'b000.
- Offset 119, step with STEP=1 → scroll_offset wraps to 0; no offset value ≥120 is ever observed.
- Two steps during DRAW → first sets pending, second sets overrun=1; exactly one extra frame follows with offset +1; overrun stays 1 through later frames.
- Assert reset at pixel (50,60) of a frame → plot, x, y and colour go to 0 in the same cycle; no frame_done; with INIT_DRAW=1 a fresh frame at offset 0 follows reset release.
- x/y ordering check over a full frame → x runs 0..159 within each row, y runs 0..119, no gaps or repeats, 19200 plots total, busy high exactly during those cycles.
